// File: rtl/multi_alu_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative mul/div unit.
interface multi_alu_unit_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            hold;
  logic            e_wait;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output valid, op, a, b, flush, hold, input e_wait, done, result);
  modport slave  (input valid, op, a, b, flush, hold, output e_wait, done, result);
endinterface

// File: rtl/multi_alu_unit.sv
// Iterative RV64M multiply/divide: radix-2 shift-add multiply, restoring divide,
// fixed 1+N cycle stall, result held in DONE until the pipeline advances.
module multi_alu_unit #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input logic             clk,
  input logic             resetn,
  multi_alu_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [3:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } op_e;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]};
  endfunction

  state_e            state;
  op_e               op_q;
  logic [CW-1:0]     cnt;
  logic              neg_q, sa_q, div0_q;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   quo, dvsr;
  logic [XLEN-1:0]   res_q;

  logic              accept, is_w, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b;

  always_comb begin
    accept   = (state == IDLE) && bus.valid && !bus.flush && (bus.op <= 4'd12);
    is_w     = bus.op >= 4'd8;
    a_signed = bus.op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_MULW, OP_DIVW, OP_REMW};
    b_signed = bus.op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM, OP_MULW, OP_DIVW, OP_REMW};
    a_ext    = is_w ? (a_signed ? sext_w(bus.a) : zext_w(bus.a)) : bus.a;
    b_ext    = is_w ? (b_signed ? sext_w(bus.b) : zext_w(bus.b)) : bus.b;
    sa       = a_signed && a_ext[XLEN-1];
    sb       = b_signed && b_ext[XLEN-1];
    mag_a    = sa ? -a_ext : a_ext;
    mag_b    = sb ? -b_ext : b_ext;
  end

  logic [2*XLEN-1:0] acc_nx, prod;
  logic [XLEN:0]     rem_sh, rem_nx;
  logic [XLEN-1:0]   quo_nx, q, r, res_nx;
  logic              fits;

  // Both datapaths step every BUSY cycle; the op only decides which one is read out.
  always_comb begin
    acc_nx = mplier[0] ? acc + mcand : acc;
    rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
    fits   = rem_sh >= {1'b0, dvsr};
    rem_nx = fits ? rem_sh - {1'b0, dvsr} : rem_sh;
    quo_nx = {quo[XLEN-2:0], fits};
    prod   = neg_q ? -acc_nx : acc_nx;
    q      = neg_q ? -quo_nx : quo_nx;
    r      = sa_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
    case (op_q)
      OP_MUL:                      res_nx = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_nx = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             res_nx = div0_q ? '1 : q;
      OP_REM, OP_REMU:             res_nx = r;
      OP_MULW:                     res_nx = sext_w(prod[XLEN-1:0]);
      OP_DIVW, OP_DIVUW:           res_nx = div0_q ? '1 : sext_w(q);
      OP_REMW, OP_REMUW:           res_nx = sext_w(r);
      default:                     res_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      op_q   <= OP_MUL;
      cnt    <= '0;
      neg_q  <= 1'b0;
      sa_q   <= 1'b0;
      div0_q <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q   <= op_e'(bus.op);
          cnt    <= is_w ? CW'(WLEN-1) : CW'(XLEN-1);
          neg_q  <= sa ^ sb;
          sa_q   <= sa;
          div0_q <= (b_ext == '0);
          acc    <= '0;
          mcand  <= {{XLEN{1'b0}}, mag_a};
          mplier <= mag_b;
          rem    <= '0;
          // W divides run only WLEN steps, so the dividend starts in the top half
          quo    <= is_w ? (mag_a << WLEN) : mag_a;
          dvsr   <= mag_b;
          state  <= BUSY;
        end
        BUSY: if (bus.flush) begin
          state <= IDLE;
        end else begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nx;
          quo    <= quo_nx;
          if (cnt == '0) begin
            res_q <= res_nx;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: if (bus.flush || !bus.hold) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.e_wait = accept || ((state == BUSY) && !bus.flush);
  assign bus.done   = !bus.flush && ((state == DONE) ||
                                     ((state == IDLE) && bus.valid && (bus.op > 4'd12)));
  assign bus.result = (state == DONE) ? res_q : '0;
endmodule

// File: tb/tb_multi_alu_unit.sv
// Directed bench for multi_alu_unit: stall length, results, hold, flush, reset.
module tb_multi_alu_unit;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  multi_alu_unit_if bus ();

  multi_alu_unit dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] exp, input int exp_stall,
                        input int hold_n);
    int n;
    n = 0;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.hold  = 1'b0;
    #1;
    while (bus.e_wait === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, " stall"}, 64'(n), 64'(exp_stall));
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " result"}, bus.result, exp);
    if (hold_n > 0) begin
      bus.hold = 1'b1;
      for (int i = 0; i < hold_n; i++) begin
        @(negedge clk);
        #1;
        check({tag, " hold wait/done"}, 64'({bus.e_wait, bus.done}), 64'd1);
        check({tag, " hold result"}, bus.result, exp);
      end
      bus.hold = 1'b0;
    end
    bus.valid = 1'b0;
    @(negedge clk);
    #1;
    check({tag, " idle"}, 64'({bus.e_wait, bus.done}), 64'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    resetn    = 1'b0;
    bus.valid = 1'b0;
    bus.op    = 4'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    #12;
    check("reset wait/done", 64'({bus.e_wait, bus.done}), 64'd0);
    check("reset result", bus.result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("MUL 7*-3", 4'd0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    run_op("MULHU", 4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("MULH -1*-1", 4'd1, '1, '1, 64'd0, 65, 0);
    run_op("MULHSU -1*2", 4'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("DIVU 10/0", 4'd5, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("REM 10/0", 4'd6, 64'd10, 64'd0, 64'd10, 65, 0);
    run_op("DIV ovf", 4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 65, 0);
    run_op("REM ovf", 4'd6, 64'h8000_0000_0000_0000, '1, 64'd0, 65, 0);
    run_op("DIVW -7/2", 4'd9, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
    run_op("REMW -7%2", 4'd11, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    run_op("MULW", 4'd8, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    run_op("REMUW", 4'd12, 64'h1234_5678_FFFF_FFFF, 64'h10, 64'd15, 33, 0);

    // Unsupported opcode completes at once with zero result and no stall.
    @(negedge clk);
    bus.valid = 1'b1;
    bus.op    = 4'd13;
    bus.a     = 64'd5;
    bus.b     = 64'd5;
    #1;
    check("op13 wait/done", 64'({bus.e_wait, bus.done}), 64'd1);
    check("op13 result", bus.result, 64'd0);
    bus.valid = 1'b0;

    // Flush in the 10th BUSY cycle.
    @(negedge clk);
    bus.valid = 1'b1;
    bus.op    = 4'd4;
    bus.a     = 64'd1000;
    bus.b     = 64'd3;
    #1;
    check("flush accept wait", 64'(bus.e_wait), 64'd1);
    repeat (10) @(negedge clk);
    #1;
    check("flush pre wait", 64'(bus.e_wait), 64'd1);
    bus.flush = 1'b1;
    bus.valid = 1'b0;
    #1;
    check("flush wait/done", 64'({bus.e_wait, bus.done}), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush idle", 64'({bus.e_wait, bus.done}), 64'd0);
    run_op("DIVU 100/7", 4'd5, 64'd100, 64'd7, 64'd14, 65, 0);

    run_op("MUL 3*5 hold", 4'd0, 64'd3, 64'd5, 64'd15, 65, 3);

    // Reset dropped while BUSY.
    @(negedge clk);
    bus.valid = 1'b1;
    bus.op    = 4'd0;
    bus.a     = 64'd3;
    bus.b     = 64'd5;
    repeat (5) @(negedge clk);
    #1;
    check("busy before reset", 64'(bus.e_wait), 64'd1);
    resetn    = 1'b0;
    bus.valid = 1'b0;
    #1;
    check("midreset wait/done", 64'({bus.e_wait, bus.done}), 64'd0);
    check("midreset result", bus.result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("DIV -20/3", 4'd4, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, 0);
    run_op("REM -20%3", 4'd6, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
